// File: rtl/batch_src_tx.sv
// Job-level stream source: parameter image with matw, then nbatch sample batches.
// Define BATCH_SRC_TX_STALL_CNT_EN to add the stall_cnt output.
module batch_src_tx #(
  parameter int PRM_WORDS = 375,
  parameter int SRC_WORDS = 500,
  parameter int AW = 14,
  parameter int DW = 32,
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [BW-1:0] nbatch,
  output logic [AW-1:0] mem_a,
  output logic          mem_re,
  input  logic [DW-1:0] mem_q,
  output logic          src_valid,
  input  logic          src_ready,
  output logic [DW-1:0] src_data,
  output logic          matw,
  output logic          run,
  output logic          last,
  input  logic          batch_done,
  output logic          busy,
  output logic          done
`ifdef BATCH_SRC_TX_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRM  = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_SRC  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  localparam int PW = $clog2(PRM_WORDS + 1);
  localparam int IW = $clog2(SRC_WORDS);
  localparam logic [PW-1:0] P_END  = PW'(PRM_WORDS);
  localparam logic [IW-1:0] I_LAST = IW'(SRC_WORDS - 1);
  localparam logic [AW-1:0] A_SRC  = AW'(PRM_WORDS);

  logic [2:0]    state;
  logic [BW-1:0] nb;
  logic [PW-1:0] pcnt;
  logic          pval;
  logic [AW-1:0] raddr;
  logic [IW-1:0] ri;
  logic [BW-1:0] rb;
  logic          rdone;
  logic          pend;
  logic [1:0]    occ;
  logic [DW-1:0] f0;
  logic [DW-1:0] f1;
  logic [IW-1:0] ti;
  logic [BW-1:0] tb;
  logic [BW:0]   dcnt;
  logic          done_q;

  logic          in_src;
  logic          prm_rd;
  logic          pop;
  logic          push;
  logic          issue;
  logic [2:0]    fill;
  logic [BW-1:0] nb_m1;
  logic          tx_end;
  logic [BW:0]   dsum;
  logic          fin;

  always_comb begin
    in_src = (state == S_SRC);
    prm_rd = (state == S_PRM) && (pcnt != P_END);
    pop    = in_src && (occ != 2'd0) && src_ready;
    push   = pend;
    // Count a word leaving this cycle as free so the FIFO streams 1/clk.
    fill   = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};
    issue  = in_src && !rdone && (fill < 3'd2);
    nb_m1  = nb - BW'(1);
    tx_end = pop && (ti == I_LAST) && (tb == nb_m1);
    dsum   = dcnt + {{BW{1'b0}},
             batch_done && (in_src || state == S_WAIT)};
    fin    = dsum >= {1'b0, nb};
  end

  always_comb begin
    mem_re    = prm_rd || issue;
    mem_a     = prm_rd ? AW'(pcnt) : (issue ? raddr : '0);
    matw      = (state == S_PRM);
    run       = in_src || (state == S_WAIT);
    busy      = (state != S_IDLE);
    done      = done_q;
    src_valid = (matw && pval) || (in_src && occ != 2'd0);
    src_data  = '0;
    if (matw && pval)
      src_data = mem_q;
    else if (in_src && occ != 2'd0)
      src_data = f0;
    last = (state == S_WAIT) ||
           (in_src && tb == nb_m1 && (ti != '0 || occ != 2'd0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      nb     <= '0;
      pcnt   <= '0;
      pval   <= 1'b0;
      raddr  <= '0;
      ri     <= '0;
      rb     <= '0;
      rdone  <= 1'b0;
      pend   <= 1'b0;
      occ    <= '0;
      f0     <= '0;
      f1     <= '0;
      ti     <= '0;
      tb     <= '0;
      dcnt   <= '0;
      done_q <= 1'b0;
    end else if (abort) begin
      state  <= S_IDLE;
      nb     <= '0;
      pcnt   <= '0;
      pval   <= 1'b0;
      raddr  <= '0;
      ri     <= '0;
      rb     <= '0;
      rdone  <= 1'b0;
      pend   <= 1'b0;
      occ    <= '0;
      f0     <= '0;
      f1     <= '0;
      ti     <= '0;
      tb     <= '0;
      dcnt   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      pval   <= prm_rd;
      pend   <= issue;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (nbatch != '0) begin
              nb    <= nbatch;
              pcnt  <= '0;
              state <= S_PRM;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_PRM: begin
          if (pcnt == P_END) state <= S_GAP;
          else pcnt <= pcnt + PW'(1);
        end
        S_GAP: begin
          raddr <= A_SRC;
          ri    <= '0;
          rb    <= '0;
          rdone <= 1'b0;
          ti    <= '0;
          tb    <= '0;
          dcnt  <= '0;
          occ   <= '0;
          state <= S_SRC;
        end
        S_SRC: begin
          dcnt <= dsum;
          if (issue) begin
            raddr <= raddr + AW'(1);
            if (ri == I_LAST) begin
              ri <= '0;
              if (rb == nb_m1) rdone <= 1'b1;
              else rb <= rb + BW'(1);
            end else begin
              ri <= ri + IW'(1);
            end
          end
          if (pop) begin
            if (ti == I_LAST) begin
              ti <= '0;
              tb <= tb + BW'(1);
            end else begin
              ti <= ti + IW'(1);
            end
          end
          // Batches already drained: skip WAIT and finish right away.
          if (tx_end) begin
            if (fin) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          dcnt <= dsum;
          if (fin) begin
            state  <= S_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (push && !pop) begin
        if (occ == 2'd0) f0 <= mem_q;
        else f1 <= mem_q;
        occ <= occ + 2'd1;
      end else if (!push && pop) begin
        f0  <= f1;
        occ <= occ - 2'd1;
      end else if (push && pop) begin
        if (occ == 2'd1) begin
          f0 <= mem_q;
        end else begin
          f0 <= f1;
          f1 <= mem_q;
        end
      end
    end
  end

`ifdef BATCH_SRC_TX_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (abort || (state == S_IDLE && start))
      stall_cnt <= '0;
    else if (in_src && occ != 2'd0 && !src_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_batch_src_tx.sv
// Randomized self-checking bench for batch_src_tx against a memory-order model.
// Covers basic job, backpressure, nbatch=0, early batch_done, abort and reset.
module tb_batch_src_tx;
  localparam int PW = 375;
  localparam int SW = 500;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [BW-1:0] nbatch = '0;
  logic [AW-1:0] mem_a;
  logic          mem_re;
  logic [DW-1:0] mem_q = '0;
  logic          src_valid;
  logic          src_ready = 1'b0;
  logic [DW-1:0] src_data;
  logic          matw;
  logic          run;
  logic          last;
  logic          batch_done = 1'b0;
  logic          busy;
  logic          done;
`ifdef BATCH_SRC_TX_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_re) mem_q <= mem[mem_a];

  batch_src_tx #(
    .PRM_WORDS(PW), .SRC_WORDS(SW), .AW(AW), .DW(DW), .BW(BW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .nbatch(nbatch), .mem_a(mem_a), .mem_re(mem_re), .mem_q(mem_q),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .matw(matw), .run(run), .last(last), .batch_done(batch_done),
    .busy(busy), .done(done)
`ifdef BATCH_SRC_TX_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"},
        {src_valid, matw, run, last, busy, done, mem_re}, 7'd0);
    chk({tag, "_addr"}, mem_a, 0);
    chk({tag, "_data"}, src_data, 0);
  endtask

  // Whole job: PRM words must be mem[0..PW-1], SRC words mem[PW..].
  task automatic run_job(input int nb, input int rpct, input bit early,
                         input string tag);
    int total;
    int pi, si, perr, serr, stab, prm_runs, src_runs, gaps, mix;
    int pulses, lastpulse, fin, done_at, cyc;
    bit pv, pr, pm, pl, psv, lok, run_pre, run_at, r;
    logic [DW-1:0] pd;
    total = nb * SW;
    pi = 0; si = 0; perr = 0; serr = 0; stab = 0;
    prm_runs = 0; src_runs = 0; gaps = 0; mix = 0;
    pulses = 0; lastpulse = -1; fin = -1; done_at = -1; cyc = 0;
    pv = 0; pr = 0; pm = 0; pl = 0; psv = 0; lok = 0;
    run_pre = 0; run_at = 1; pd = '0;
    @(negedge clk);
    nbatch = BW'(nb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (done_at < 0 && cyc < 30000) begin
      batch_done = 1'b0;
      if (done) begin
        done_at = cyc;
        run_at = run;
      end else begin
        if (matw && src_valid) begin
          if (!pm) prm_runs++;
          if (pi >= PW || src_data !== mem[pi]) perr++;
          pi++;
        end
        if (matw && run) mix++;
        if (busy && !matw && !run) gaps++;
        r = ($urandom_range(99) < rpct);
        if (run) begin
          if (pv && !pr && (!src_valid || src_data !== pd)) stab++;
          if (src_valid && !psv) src_runs++;
          if (last && !pl)
            lok = src_valid && (src_data === mem[PW + (nb-1)*SW]);
          if (src_valid && r) begin
            if (si >= total || src_data !== mem[PW + si]) serr++;
            si++;
            if (si == total) fin = cyc + 1;
          end
        end
        pm = matw && src_valid;
        pv = src_valid && run;
        psv = pv;
        pr = r;
        pd = src_data;
        pl = last;
        run_pre = run;
        if (early) begin
          if (pulses < nb && si >= 100 * (pulses + 1)) begin
            batch_done = 1'b1; pulses++; lastpulse = cyc;
          end
        end else if (pulses < nb - 1 && si >= (pulses + 1) * SW) begin
          batch_done = 1'b1; pulses++; lastpulse = cyc;
        end else if (pulses == nb - 1 && fin >= 0 && cyc >= fin + 3) begin
          batch_done = 1'b1; pulses++; lastpulse = cyc;
        end
        src_ready = r;
        @(negedge clk);
        cyc++;
      end
    end
    batch_done = 1'b0;
    chk({tag, "_done_seen"}, done_at >= 0, 1);
    chk({tag, "_prm_words"}, pi, PW);
    chk({tag, "_prm_data_err"}, perr, 0);
    chk({tag, "_prm_runs"}, prm_runs, 1);
    chk({tag, "_matw_run"}, mix, 0);
    chk({tag, "_gap_cycles"}, gaps, 1);
    chk({tag, "_src_words"}, si, total);
    chk({tag, "_src_data_err"}, serr, 0);
    chk({tag, "_stall_hold_err"}, stab, 0);
    chk({tag, "_last_word"}, lok, 1);
    if (rpct == 100) chk({tag, "_src_runs"}, src_runs, 1);
    chk({tag, "_done_time"}, done_at, early ? fin : lastpulse + 1);
    chk({tag, "_run_at_done"}, run_at, 0);
    chk({tag, "_run_before_done"}, run_pre, 1);
    @(negedge clk);
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_idle_after"}, busy, 0);
  endtask

  task automatic wait_src(input string tag);
    int w;
    w = 0;
    while (!(run && src_valid) && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_reach_src"}, w < 3000, 1);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    chk_idle("in_reset");
    reset = 1'b0;
    @(negedge clk);
    chk_idle("after_reset");

    run_job(2, 100, 1'b0, "basic");
    run_job(3, 50, 1'b0, "bp");

    @(negedge clk);
    nbatch = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("nb0_done", done, 1);
    chk("nb0_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (matw || run || src_valid) seen++;
      @(negedge clk);
    end
    chk("nb0_quiet", seen, 0);
    chk("nb0_done_once", done, 0);

    run_job(1, 100, 1'b1, "early");

    nbatch = 8'd1;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_prio_busy", busy, 0);

    src_ready = 1'b1;
    nbatch = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_src("abort");
    repeat (20) @(negedge clk);
    src_ready = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_valid", src_valid, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("abort");
    run_job(1, 70, 1'b0, "replay");

    nbatch = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    chk("prm_before_reset", matw, 1);
    #2 reset = 1'b1;
    #1 chk_idle("async_reset");
    @(negedge clk);
    reset = 1'b0;

`ifdef BATCH_SRC_TX_STALL_CNT_EN
    src_ready = 1'b1;
    nbatch = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_src("stall");
    repeat (5) @(negedge clk);
    src_ready = 1'b0;
    repeat (7) @(negedge clk);
    src_ready = 1'b1;
    chk("stall_cnt", stall_cnt, 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
`endif

    run_job(2, 80, 1'b0, "post");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
